uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Synthesizable 8-bit UART transmitter with a small input FIFO, the transmit-side counterpart of the testbench UART monitor that decodes `ser_tx`-style serial lines. It sits between a byte-producing master (firmware-facing register block or test logic) and the `ser_tx` pad. It serialises bytes as LSB-first 8N1 frames at a fixed clocks-per-bit ratio. Back-to-back bytes go out with no idle gap.

## Interface
- `CLK_DIV`, default 16: clock cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH`, default 4: byte entries in the input FIFO; power of two, ≥2.
- `clk`  input  1  single clock for all logic.
- `rst`  input  1  asynchronous, active-high reset.
- `tx_data`  input  8  byte to transmit.
- `tx_valid`  input  1  `tx_data` is valid this cycle.
- `tx_ready`  output  1  FIFO can accept a byte; equals `!full`.
- `ser_tx`  output  1  serial line, idle high; registered.
- `busy`  output  1  high when a frame is in progress or the FIFO is non-empty.
- `fifo_level`  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Push:** a byte is written on a rising edge with `tx_valid && tx_ready`. Pushes while full cannot occur because `tx_ready` is low then; `tx_valid` without `tx_ready` is ignored.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register and go to START. Otherwise stay, with `ser_tx`=1.
  - START: `ser_tx`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `ser_tx`=shift[0] for CLK_DIV cycles, then shift right. After bit index 7, go to PARITY (if enabled) or STOP.
  - STOP: `ser_tx`=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- **Divider:** a 16-bit counter reloads to 0 on every state or bit change and advances 0..CLK_DIV-1. The bit boundary is at count == CLK_DIV-1.
- **Simultaneous push and pop:** allowed in the same cycle, and the level is unchanged. A push into an empty FIFO is visible to the FSM the next cycle; there is no combinational bypass.
- **Pointers:** read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty are derived from `fifo_level`.
- **Streaming:** `tx_data` changing while a frame is in flight has no effect on that frame.

## Timing
- **Reset values:** `ser_tx`=1, `tx_ready`=1, `busy`=0, `fifo_level`=0, state IDLE, and FIFO pointers 0.
- **Reset mid-frame:** the frame is aborted immediately (asynchronously) with `ser_tx`=1, and all queued bytes are discarded.
- **Latency:** a byte accepted at edge N into an empty FIFO with the FSM in IDLE drives `ser_tx` low from edge N+2. That is one cycle to update the FIFO, then one cycle for the FSM pop and the registered output.
- **Frame length:** exactly 10×CLK_DIV cycles, or 11×CLK_DIV with parity. Consecutive queued frames abut with zero idle cycles.
- **`busy`:** falls in the same cycle the FSM returns to IDLE with the FIFO empty.
- **`tx_ready`:** falls the cycle after the push that fills the FIFO, and rises the cycle after the pop that frees an entry.

## Configuration
- Macro `UART_TX_PARITY_EN`.
  - Defined: the PARITY state is inserted after DATA and drives the even parity bit (XOR of the 8 data bits) for CLK_DIV cycles. Frames are 8E1, 11 bits long.
  - Undefined: the PARITY state and its logic are absent. Frames are 8N1, 10 bits long.

## Test plan
- **Reset state:** with CLK_DIV=4, hold `rst`=1 and then release it. Required: `ser_tx`=1, `tx_ready`=1, `busy`=0, `fifo_level`=0, and `ser_tx` stays 1 for 100 cycles.
- **Single byte:** with CLK_DIV=4, push 0x55 once. Required: `ser_tx` starts 2 cycles after the push and holds each value for 4 cycles in the sequence 0,1,0,1,0,1,0,1,0,1. The frame lasts 40 cycles, and `busy` then falls.
- **Back-to-back:** with CLK_DIV=4, push 0xA3, 0x0A, 0xFF on consecutive cycles. Required: three frames lasting 120 contiguous cycles with no idle gap. A testbench UART decoder must recover 0xA3, 0x0A, 0xFF in that order.
- **Full FIFO:** with FIFO_DEPTH=4, push 6 bytes with `tx_valid` held high. Required: `tx_ready` drops once the FIFO holds 4 queued bytes while the first frame is active. Exactly the accepted bytes are transmitted, in order, with none lost or duplicated. `fifo_level` never exceeds 4.
- **Reset mid-frame:** assert `rst` during DATA bit 3 of 0x00 with 2 further bytes queued. Required: `ser_tx`=1 asynchronously, `fifo_level`=0, and no further frames after release.
- **Parity:** with `UART_TX_PARITY_EN` defined, send 0x07. Required: the parity bit is 1 and the frame is 44 cycles at CLK_DIV=4. Sending 0x03 must give parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: LSB-first UART transmitter fed by a small byte FIFO; 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1 frames).
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        ser_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          ser_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop, at_end, line_d;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    assign at_end     = cnt_q == LAST;
    assign tx_ready   = level_q != LW'(FIFO_DEPTH);
    assign push       = tx_valid && tx_ready;
    // Pop either from idle or exactly at the end of a stop bit, so queued frames abut.
    assign pop        = level_q != '0 && (state_q == IDLE || (state_q == STOP && at_end));
    assign level_d    = level_q + LW'(push) - LW'(pop);
    assign busy       = state_q != IDLE || level_q != '0;
    assign fifo_level = level_q;
    assign ser_tx     = ser_q;

`ifdef UART_TX_PARITY_EN
    assign line_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PARITY ? par_q : 1'b1;
`else
    assign line_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= tx_data;
    end

    // The line is registered from the current state, so it trails the FSM by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ser_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            ser_q <= line_d;
            cnt_q <= (state_q == IDLE || at_end) ? '0 : cnt_q + 16'd1;
            if (pop) begin
                state_q <= START;
                shift_q <= mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
                par_q   <= ^mem_q[rptr_q];
`endif
            end else if (at_end) begin
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        bit_q   <= '0;
                    end
                    DATA: begin
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                        if (bit_q == 3'd7) state_q <= PARITY;
`else
                        if (bit_q == 3'd7) state_q <= STOP;
`endif
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: state_q <= STOP;
`endif
                    STOP: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at CLK_DIV=4, FIFO_DEPTH=4 with a line decoder.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int D   = 4;
    localparam int PER = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ser_tx, busy;
    logic [2:0] fifo_level;

    int         n_chk = 0;
    int         n_fail = 0;
    int         rx_err = 0;
    int         max_lvl = 0;
    int         w;
    logic [7:0] rx_q [$];
    time        t_start [$];
    logic [7:0] dec_b;
    logic       dec_s;
`ifdef UART_TX_PARITY_EN
    logic       par_s [$];
`endif
    logic [7:0] exp3 [3] = '{8'hA3, 8'h0A, 8'hFF};
    logic [7:0] exp6 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    uart_tx_fifo #(.CLK_DIV(D), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ser_tx(ser_tx), .busy(busy), .fifo_level(fifo_level)
    );

    always #(PER/2) clk = ~clk;

    always @(negedge clk) if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);

    // Independent receiver: samples mid-bit on falling clock edges after each start edge.
    initial begin
        forever begin
            @(negedge ser_tx);
            t_start.push_back($time);
            repeat (2) @(negedge clk);
            dec_s = ser_tx;
            for (int k = 0; k < 8; k++) begin
                repeat (D) @(negedge clk);
                dec_b[k] = ser_tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (D) @(negedge clk);
            par_s.push_back(ser_tx);
            if (ser_tx !== ^dec_b) rx_err++;
`endif
            repeat (D) @(negedge clk);
            if (dec_s !== 1'b0 || ser_tx !== 1'b1) rx_err++;
            rx_q.push_back(dec_b);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic send_check(input logic [7:0] b, input string tag);
        logic [10:0] f;
        f = frame(b);
        tx_data = b;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        check({tag, "_lvl"}, 32'(fifo_level), 1);
        tick;
        check({tag, "_pre"}, 32'(ser_tx), 1);
        check({tag, "_busy"}, 32'(busy), 1);
        for (int i = 0; i < NB*D; i++) begin
            tick;
            check($sformatf("%s_bit%0d_cyc%0d", tag, i/D, i), 32'(ser_tx), 32'(f[i/D]));
            if (i == NB*D-2) check({tag, "_busy_last"}, 32'(busy), 1);
        end
        check({tag, "_busy_end"}, 32'(busy), 0);
        tick;
        check({tag, "_post"}, 32'(ser_tx), 1);
    endtask

    initial begin
        repeat (3) tick;
        check("rst_ser", 32'(ser_tx), 1);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_lvl", 32'(fifo_level), 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick;
            check($sformatf("idle_ser_%0d", i), 32'(ser_tx), 1);
        end
        check("idle_busy", 32'(busy), 0);

        send_check(8'h55, "single55");
        repeat (4) tick;
        check("single_rx_n", 32'(rx_q.size()), 1);
        check("single_rx", 32'(rx_q[0]), 32'h55);

        rx_q.delete();
        t_start.delete();
        tx_valid = 1'b1;
        tx_data = 8'hA3;
        tick;
        tx_data = 8'h0A;
        tick;
        check("b2b_pre", 32'(ser_tx), 1);
        tx_data = 8'hFF;
        tick;
        tx_valid = 1'b0;
        check("b2b_start", 32'(ser_tx), 0);
        check("b2b_lvl", 32'(fifo_level), 2);
        repeat (3*NB*D + 10) tick;
        check("b2b_rx_n", 32'(rx_q.size()), 3);
        for (int i = 0; i < 3; i++) check($sformatf("b2b_rx%0d", i), 32'(rx_q[i]), 32'(exp3[i]));
        check("b2b_starts", 32'(t_start.size()), 3);
        check("b2b_gap01", 32'(t_start[1] - t_start[0]), NB*D*PER);
        check("b2b_gap12", 32'(t_start[2] - t_start[1]), NB*D*PER);
        check("b2b_busy", 32'(busy), 0);
        check("b2b_err", 32'(rx_err), 0);

        rx_q.delete();
        t_start.delete();
        tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_data = exp6[i];
            tick;
        end
        check("full_lvl", 32'(fifo_level), 4);
        check("full_ready", 32'(tx_ready), 0);
        check("full_ser", 32'(ser_tx), 0);
        tx_data = exp6[5];
        w = 0;
        while (!tx_ready && w < 60) begin
            tick;
            w++;
        end
        check("full_wait", 32'(w), NB*D - 3);
        tick;
        tx_valid = 1'b0;
        check("full_refill_lvl", 32'(fifo_level), 4);
        check("full_refill_ready", 32'(tx_ready), 0);
        repeat (6*NB*D + 10) tick;
        check("full_rx_n", 32'(rx_q.size()), 6);
        for (int i = 0; i < 6; i++) check($sformatf("full_rx%0d", i), 32'(rx_q[i]), 32'(exp6[i]));
        check("full_max_lvl", 32'(max_lvl), 4);
        check("full_busy", 32'(busy), 0);
        check("full_err", 32'(rx_err), 0);

`ifdef UART_TX_PARITY_EN
        send_check(8'h07, "par07");
        repeat (4) tick;
        check("par07_bit", 32'(par_s[$]), 1);
        send_check(8'h03, "par03");
        repeat (4) tick;
        check("par03_bit", 32'(par_s[$]), 0);
        check("par_err", 32'(rx_err), 0);
`endif

        rx_q.delete();
        t_start.delete();
        tx_valid = 1'b1;
        tx_data = 8'h00;
        tick;
        tx_data = 8'h5A;
        tick;
        tx_data = 8'hC3;
        tick;
        tx_valid = 1'b0;
        repeat (17) tick;
        check("abort_bit3", 32'(ser_tx), 0);
        check("abort_lvl_pre", 32'(fifo_level), 2);
        #3;
        rst = 1'b1;
        #1;
        check("abort_ser", 32'(ser_tx), 1);
        check("abort_lvl", 32'(fifo_level), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(tx_ready), 1);
        repeat (2) tick;
        rst = 1'b0;
        repeat (200) tick;
        check("abort_starts", 32'(t_start.size()), 1);
        check("abort_ser_idle", 32'(ser_tx), 1);
        check("abort_busy_idle", 32'(busy), 0);
        check("abort_lvl_idle", 32'(fifo_level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
